dec_scan_ctrl: RTL and testbench
================================

// Module: dec_scan_ctrl
// PURPOSE
//   Upstream sequencer for the dec1x2/dec2x4/dec3x8 decoder family. Steps a registered select code
//   0..2^SEL_W-1 and a decoder enable, holding each code a programmable number of cycles.
//   Supports one-shot and continuous scans, with start/stop control and busy/done/wrap status.
//   sel[SEL_W-1:0] maps to the decoder inputs, MSB first (a,b,c for dec3x8); en drives the decoder en.
// PARAMETERS
//   SEL_W    3   select code width; 2^SEL_W codes per scan (1..6)
//   DWELL_W  8   width of the dwell input; each code is held dwell+1 cycles
// PORTS
//   clk        in   1        single clock, rising edge
//   rst        in   1        synchronous, active-high reset
//   start      in   1        level; sampled in IDLE only; begins a scan
//   stop       in   1        level; aborts a scan, no done pulse
//   mode_cont  in   1        1 = continuous (wraps), 0 = one-shot; latched with start
//   dwell      in   DWELL_W  hold count per code minus one; latched with start
//   sel        out  SEL_W    registered select code to the decoder
//   en         out  1        registered decoder enable
//   busy       out  1        high while in SCAN (or BLANK)
//   done       out  1        1-cycle pulse when a one-shot scan completes
//   wrap       out  1        1-cycle pulse on the first cycle of code 0 after a wrap (continuous mode)
// BEHAVIOUR
//   - All outputs are registered. Reset values: sel=0, en=0, busy=0, done=0, wrap=0; state=IDLE.
//   - rst dominates everything. If rst is asserted mid-scan, the next edge restores the reset values
//     and no done pulse is issued.
//   - States: IDLE, SCAN (plus BLANK when DEC_SCAN_BLANK_EN is defined).
//   - IDLE, start=1, stop=0 -> SCAN at the next edge with sel=0, en=1, busy=1.
//     * dwell and mode_cont are latched on the same edge.
//     * Latency is 1 cycle, start edge to en=1.
//   - IDLE, start=1 and stop=1 together -> remain in IDLE.
//   - SCAN: dwell counter loads dwell_q on each code entry and decrements every cycle.
//     At count 0 the code ends:
//     * sel < max: sel <= sel+1 and the counter reloads.
//     * sel == max, continuous: sel <= 0 and wrap <= 1 for one cycle.
//     * sel == max, one-shot: -> IDLE with en=0, busy=0, sel=0, and done=1 for that one cycle.
//   - stop=1 in SCAN or BLANK -> IDLE at the next edge (en=0, busy=0, sel=0, done=0).
//     stop takes priority over code advance and completion.
//   - start while busy is ignored. Changes to dwell or mode_cont mid-scan are ignored.
//   - dwell=0 gives 1 cycle per code; dwell=2^DWELL_W-1 gives 2^DWELL_W cycles.
//   - One-shot en-high cycles = 2^SEL_W*(dwell+1).
// CONFIGURATION
//   DEC_SCAN_BLANK_EN defined:
//     - One BLANK cycle is inserted between consecutive codes, including the wrap 7->0.
//     - During BLANK: en=0, sel already holds the next code, busy=1.
//     - wrap pulses on the first en-high cycle of code 0, not on the BLANK cycle.
//     - No BLANK follows the final code of a one-shot scan.
//     - One-shot total = 2^SEL_W*(dwell+1) + 2^SEL_W-1 cycles.
//   DEC_SCAN_BLANK_EN undefined: en stays continuously high across code changes; no BLANK state.
// STRUCTURE
//   - dec_pkg holds the state typedef (IDLE/SCAN/BLANK), the SEL_W and DWELL_W defaults,
//     and the SEL_MAX helper function.
//   - Sub-module dec_scan_timer: loadable down-counter (load, dec, zero flag), DWELL_W wide.
//   - FSM, sel register and output registers live in dec_scan_ctrl.
// TESTING
//   1. SEL_W=3, dwell=0, one-shot; start for 1 cycle:
//      sel 0..7 one cycle each, en=1 for 8 cycles. On the next cycle done=1, en=0, busy=0, sel=0.
//   2. dwell=2, one-shot: each code held 3 cycles, en high for 24 cycles, then a single done pulse.
//   3. Continuous, dwell=0: sel 7->0 with wrap=1 on the sel=0 cycle; done is never asserted.
//      stop at sel=4 -> next cycle en=0, busy=0, sel=0, done=0.
//   4. rst asserted while sel=5 -> next cycle sel=0, en=0, busy=0, done=0, wrap=0; no done pulse follows.
//   5. start+stop together in IDLE -> stays IDLE.
//      start pulsed at sel=3 mid-scan -> no restart; scan ends at the normal time.
//   6. DEC_SCAN_BLANK_EN, dwell=0, one-shot: en = 1,0,1,0,...,1 (8 highs, 7 lows).
//      sel increments on the low cycles; done comes 15 cycles after en first rises.
//      Check the decoder outputs one-hot per en-high cycle.

Source files
------------

// File: rtl/dec_pkg.sv
// Shared types and defaults for the decoder scan sequencer.
// The optional blank-cycle feature is controlled by DEC_SCAN_BLANK_EN; see dec_scan_ctrl.
package dec_pkg;

   localparam int unsigned SEL_W_DEF   = 3;
   localparam int unsigned DWELL_W_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_BLANK = 2'd2
   } scan_state_e;

   // Highest select code for a given select width
   function automatic int unsigned SEL_MAX(input int unsigned sel_w);
      return (32'd1 << sel_w) - 32'd1;
   endfunction

endpackage

// File: rtl/dec_scan_timer.sv
// Loadable dwell down-counter; the zero flag marks the last cycle of a code.
module dec_scan_timer
   import dec_pkg::*;
#(
   parameter int unsigned W = DWELL_W_DEF
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_i,
   input  logic         dec_i,
   input  logic [W-1:0] val_i,
   output logic         zero_c_o
);

   logic [W-1:0] cnt_q, cnt_d;

   // Load has priority; decrement saturates at zero
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   // Counter register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_c_o = (cnt_q == '0);

endmodule

// File: rtl/dec_scan_ctrl.sv
// Select-code scan sequencer driving the dec1x2/dec2x4/dec3x8 decoder family.
// Define DEC_SCAN_BLANK_EN to insert one en-low BLANK cycle between consecutive codes.
module dec_scan_ctrl
   import dec_pkg::*;
#(
   parameter int unsigned SEL_W   = SEL_W_DEF,
   parameter int unsigned DWELL_W = DWELL_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               stop,
   input  logic               mode_cont,
   input  logic [DWELL_W-1:0] dwell,
   output logic [SEL_W-1:0]   sel,
   output logic               en,
   output logic               busy,
   output logic               done,
   output logic               wrap
);

   localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(SEL_MAX(SEL_W));

   scan_state_e        state_q, state_d;
   logic [SEL_W-1:0]   sel_q, sel_d;
   logic               en_q, en_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               wrap_q, wrap_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic               cont_q, cont_d;

   logic               tmr_load_c;
   logic               tmr_dec_c;
   logic [DWELL_W-1:0] tmr_val_c;
   logic               tmr_zero_c;

   dec_scan_timer #(
      .W (DWELL_W)
   ) u_timer (
      .clk_i    (clk),
      .rst_i    (rst),
      .load_i   (tmr_load_c),
      .dec_i    (tmr_dec_c),
      .val_i    (tmr_val_c),
      .zero_c_o (tmr_zero_c)
   );

   // Next-state, next-output and timer control
   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      en_d       = en_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      wrap_d     = 1'b0;
      dwell_d    = dwell_q;
      cont_d     = cont_q;
      tmr_load_c = 1'b0;
      tmr_dec_c  = 1'b0;
      tmr_val_c  = dwell_q;

      case (state_q)
         ST_IDLE: begin
            sel_d  = '0;
            en_d   = 1'b0;
            busy_d = 1'b0;
            if (start && !stop) begin
               state_d    = ST_SCAN;
               en_d       = 1'b1;
               busy_d     = 1'b1;
               dwell_d    = dwell;
               cont_d     = mode_cont;
               tmr_load_c = 1'b1;
               tmr_val_c  = dwell;
            end
         end

         ST_SCAN: begin
            if (stop) begin
               state_d = ST_IDLE;
               sel_d   = '0;
               en_d    = 1'b0;
               busy_d  = 1'b0;
            end else if (!tmr_zero_c) begin
               tmr_dec_c = 1'b1;
            end else if (sel_q != SEL_LAST) begin
               sel_d = sel_q + SEL_W'(1);
`ifdef DEC_SCAN_BLANK_EN
               state_d = ST_BLANK;
               en_d    = 1'b0;
`else
               tmr_load_c = 1'b1;
`endif
            end else if (cont_q) begin
               sel_d = '0;
`ifdef DEC_SCAN_BLANK_EN
               state_d = ST_BLANK;
               en_d    = 1'b0;
`else
               wrap_d     = 1'b1;
               tmr_load_c = 1'b1;
`endif
            end else begin
               state_d = ST_IDLE;
               sel_d   = '0;
               en_d    = 1'b0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end

         ST_BLANK: begin
            if (stop) begin
               state_d = ST_IDLE;
               sel_d   = '0;
               en_d    = 1'b0;
               busy_d  = 1'b0;
            end else begin
               // Only a wrap lands in BLANK holding code 0
               state_d    = ST_SCAN;
               en_d       = 1'b1;
               wrap_d     = (sel_q == '0);
               tmr_load_c = 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
            sel_d   = '0;
            en_d    = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         sel_q   <= '0;
         en_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         wrap_q  <= 1'b0;
         dwell_q <= '0;
         cont_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         en_q    <= en_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         wrap_q  <= wrap_d;
         dwell_q <= dwell_d;
         cont_q  <= cont_d;
      end
   end

   assign sel  = sel_q;
   assign en   = en_q;
   assign busy = busy_q;
   assign done = done_q;
   assign wrap = wrap_q;

endmodule

// File: tb/tb_dec_scan_ctrl.sv
// Self-checking bench for dec_scan_ctrl (SEL_W=3, DWELL_W=8); follows DEC_SCAN_BLANK_EN when defined.
module tb_dec_scan_ctrl;

   typedef struct packed {
      logic [2:0] sel;
      logic       en;
      logic       busy;
      logic       done;
      logic       wrap;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       stop;
   logic       mode_cont;
   logic [7:0] dwell;
   logic [2:0] sel;
   logic       en;
   logic       busy;
   logic       done;
   logic       wrap;

   int   total = 0;
   int   bad   = 0;
   exp_t q[$];

   always #5 clk = ~clk;

   dec_scan_ctrl #(
      .SEL_W   (3),
      .DWELL_W (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .stop      (stop),
      .mode_cont (mode_cont),
      .dwell     (dwell),
      .sel       (sel),
      .en        (en),
      .busy      (busy),
      .done      (done),
      .wrap      (wrap)
   );

   function automatic exp_t obs();
      exp_t o;
      o.sel  = sel;
      o.en   = en;
      o.busy = busy;
      o.done = done;
      o.wrap = wrap;
      return o;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Expected per-cycle outputs for the n cycles following the start edge
   task automatic push_scan(input int d, input bit cont, input int n);
      bit   first;
      exp_t e;
      first = 1'b1;
      q.delete();
      do begin
         for (int k = 0; k < 8; k++) begin
`ifdef DEC_SCAN_BLANK_EN
            if (!(k == 0 && first)) begin
               e.sel = 3'(k); e.en = 1'b0; e.busy = 1'b1; e.done = 1'b0; e.wrap = 1'b0;
               q.push_back(e);
            end
`endif
            for (int r = 0; r <= d; r++) begin
               e.sel  = 3'(k);
               e.en   = 1'b1;
               e.busy = 1'b1;
               e.done = 1'b0;
               e.wrap = (k == 0 && !first && r == 0);
               q.push_back(e);
            end
         end
         first = 1'b0;
      end while (cont && q.size() < n);
      if (!cont) begin
         e = '0;
         e.done = 1'b1;
         q.push_back(e);
      end
      while (q.size() < n) q.push_back(exp_t'(7'd0));
      while (q.size() > n) void'(q.pop_back());
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; stop = 1'b0; mode_cont = 1'b0; dwell = 8'd0;
      step();
      step();
      total++;
      if (obs() !== exp_t'(7'd0)) begin
         bad++;
         $display("FAIL reset got=%b exp=%b", obs(), exp_t'(7'd0));
      end
      rst = 1'b0;
      step();
      total++;
      if (obs() !== exp_t'(7'd0)) begin
         bad++;
         $display("FAIL reset_idle got=%b exp=%b", obs(), exp_t'(7'd0));
      end
   endtask

   task automatic test_oneshot(input int d);
      int   n;
      exp_t e;
      n = 8 * (d + 1) + 7 + 4;
      dwell = 8'(d); mode_cont = 1'b0; start = 1'b1;
      push_scan(d, 1'b0, n);
      for (int i = 0; i < n; i++) begin
         step();
         if (i == 0) begin
            start = 1'b0;
            dwell = 8'd9;
         end
         e = q.pop_front();
         total++;
         if (obs() !== e) begin
            bad++;
            $display("FAIL oneshot_d%0d cyc=%0d got=%b exp=%b", d, i, obs(), e);
         end
      end
   endtask

   task automatic test_cont_stop();
      exp_t e;
      int   wraps;
      dwell = 8'd0; mode_cont = 1'b1; start = 1'b1;
      wraps = 0;
      push_scan(0, 1'b1, 64);
      for (int i = 0; i < 64; i++) begin
         step();
         if (i == 0) begin
            start = 1'b0;
            mode_cont = 1'b0;
         end
         e = q.pop_front();
         total++;
         if (obs() !== e) begin
            bad++;
            $display("FAIL cont cyc=%0d got=%b exp=%b", i, obs(), e);
         end
         if (wrap === 1'b1) wraps++;
         if (e.sel == 3'd4 && e.en && wraps == 1) break;
      end
      total++;
      if (wraps != 1) begin
         bad++;
         $display("FAIL cont_wraps got=%0d exp=1", wraps);
      end
      stop = 1'b1;
      step();
      stop = 1'b0;
      total++;
      if (obs() !== exp_t'(7'd0)) begin
         bad++;
         $display("FAIL stop got=%b exp=%b", obs(), exp_t'(7'd0));
      end
      for (int i = 0; i < 4; i++) begin
         step();
         total++;
         if (obs() !== exp_t'(7'd0)) begin
            bad++;
            $display("FAIL stop_idle cyc=%0d got=%b exp=%b", i, obs(), exp_t'(7'd0));
         end
      end
   endtask

   task automatic test_rst_mid();
      exp_t e;
      dwell = 8'd1; mode_cont = 1'b0; start = 1'b1;
      push_scan(1, 1'b0, 40);
      for (int i = 0; i < 40; i++) begin
         step();
         if (i == 0) start = 1'b0;
         e = q.pop_front();
         total++;
         if (obs() !== e) begin
            bad++;
            $display("FAIL rst_mid_pre cyc=%0d got=%b exp=%b", i, obs(), e);
         end
         if (e.sel == 3'd5 && e.en) break;
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      total++;
      if (obs() !== exp_t'(7'd0)) begin
         bad++;
         $display("FAIL rst_mid got=%b exp=%b", obs(), exp_t'(7'd0));
      end
      for (int i = 0; i < 20; i++) begin
         step();
         total++;
         if (obs() !== exp_t'(7'd0)) begin
            bad++;
            $display("FAIL rst_mid_after cyc=%0d got=%b exp=%b", i, obs(), exp_t'(7'd0));
         end
      end
   endtask

   task automatic test_start_stop_idle();
      dwell = 8'd0; mode_cont = 1'b0; start = 1'b1; stop = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         total++;
         if (obs() !== exp_t'(7'd0)) begin
            bad++;
            $display("FAIL start_stop cyc=%0d got=%b exp=%b", i, obs(), exp_t'(7'd0));
         end
      end
      start = 1'b0; stop = 1'b0;
      step();
   endtask

   task automatic test_start_midscan();
      exp_t e;
      bit   pulsed;
      int   n;
      n = 8 * 2 + 7 + 4;
      pulsed = 1'b0;
      dwell = 8'd1; mode_cont = 1'b0; start = 1'b1;
      push_scan(1, 1'b0, n);
      for (int i = 0; i < n; i++) begin
         step();
         start = 1'b0;
         e = q.pop_front();
         total++;
         if (obs() !== e) begin
            bad++;
            $display("FAIL start_mid cyc=%0d got=%b exp=%b", i, obs(), e);
         end
         if (e.sel == 3'd3 && e.en && !pulsed) begin
            pulsed = 1'b1;
            start = 1'b1;
            dwell = 8'd5;
            mode_cont = 1'b1;
         end
      end
      mode_cont = 1'b0;
   endtask

   task automatic test_dwell_max();
      exp_t e;
      dwell = 8'd255; mode_cont = 1'b0; start = 1'b1;
      push_scan(255, 1'b0, 300);
      for (int i = 0; i < 300; i++) begin
         step();
         if (i == 0) start = 1'b0;
         e = q.pop_front();
         total++;
         if (obs() !== e) begin
            bad++;
            $display("FAIL dwell_max cyc=%0d got=%b exp=%b", i, obs(), e);
         end
      end
      stop = 1'b1;
      step();
      stop = 1'b0;
      total++;
      if (obs() !== exp_t'(7'd0)) begin
         bad++;
         $display("FAIL dwell_max_stop got=%b exp=%b", obs(), exp_t'(7'd0));
      end
   endtask

`ifdef DEC_SCAN_BLANK_EN
   task automatic test_blank();
      exp_t       e;
      logic [7:0] dec_out;
      logic [7:0] dec_exp;
      int         en_hi;
      int         en_lo;
      int         first_en;
      int         done_at;
      en_hi = 0; en_lo = 0; first_en = -1; done_at = -1;
      dwell = 8'd0; mode_cont = 1'b0; start = 1'b1;
      push_scan(0, 1'b0, 20);
      for (int i = 0; i < 20; i++) begin
         step();
         if (i == 0) start = 1'b0;
         e = q.pop_front();
         total++;
         if (obs() !== e) begin
            bad++;
            $display("FAIL blank cyc=%0d got=%b exp=%b", i, obs(), e);
         end
         if (busy === 1'b1 && en === 1'b1) en_hi++;
         if (busy === 1'b1 && en === 1'b0) en_lo++;
         if (en === 1'b1 && first_en < 0) first_en = i;
         if (done === 1'b1 && done_at < 0) done_at = i;
         if (e.en) begin
            dec_out = 8'd1 << sel;
            dec_exp = 8'd1 << e.sel;
            total++;
            if (!$onehot(dec_out) || dec_out !== dec_exp) begin
               bad++;
               $display("FAIL blank_onehot cyc=%0d got=%b exp=%b", i, dec_out, dec_exp);
            end
         end
      end
      total++;
      if (en_hi != 8 || en_lo != 7) begin
         bad++;
         $display("FAIL blank_counts got hi=%0d lo=%0d exp hi=8 lo=7", en_hi, en_lo);
      end
      total++;
      if (done_at - first_en != 15) begin
         bad++;
         $display("FAIL blank_done_lat got=%0d exp=15", done_at - first_en);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_oneshot(0);
      test_oneshot(2);
      test_cont_stop();
      test_rst_mid();
      test_start_stop_idle();
      test_start_midscan();
      test_dwell_max();
`ifdef DEC_SCAN_BLANK_EN
      test_blank();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
